// File: rtl/data_path_seq_pkg.sv
// Shared types and width constants for the data_path host sequencer.
package data_path_seq_pkg;

    localparam int DATA_W_DEF      = 48;
    localparam int CODE_W_DEF      = 12;
    localparam int IDX_W_DEF       = 32;
    localparam int WDOG_CYCLES_DEF = 1000000;

    typedef enum logic [2:0] {
        OP_LOAD_CODE   = 3'd0,
        OP_LOAD_WEIGHT = 3'd1,
        OP_LOAD_INPUT  = 3'd2,
        OP_LOAD_LABEL  = 3'd3,
        OP_RUN         = 3'd4
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RSTLOC = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    function automatic logic op_is_load(input logic [2:0] op);
        return (op < 3'd4);
    endfunction

endpackage

// File: rtl/data_path_sequencer_matrix_index_counter.sv
// Row/layer index generator for matrix loads; row wraps after rows-1 and bumps the layer.
module matrix_index_counter #(
    parameter int IDX_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [IDX_W-1:0] rows,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] layer
);

    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] row_r;
    logic [IDX_W-1:0] layer_r;
    logic [IDX_W-1:0] row_nxt_s;
    logic [IDX_W-1:0] layer_nxt_s;

    // Next index pair after the current one has been used.
    always_comb begin
        row_nxt_s   = row_r;
        layer_nxt_s = layer_r;
        if (row_r == (rows - ONE_IDX)) begin
            row_nxt_s   = ZERO_IDX;
            layer_nxt_s = layer_r + ONE_IDX;
        end else begin
            row_nxt_s   = row_r + ONE_IDX;
            layer_nxt_s = layer_r;
        end
    end

    // Index registers: cleared at command start, advanced once per written word.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r   <= ZERO_IDX;
            layer_r <= ZERO_IDX;
        end else if (clear) begin
            row_r   <= ZERO_IDX;
            layer_r <= ZERO_IDX;
        end else if (step) begin
            row_r   <= row_nxt_s;
            layer_r <= layer_nxt_s;
        end else begin
            row_r   <= row_r;
            layer_r <= layer_r;
        end
    end

    assign row   = row_r;
    assign layer = layer_r;

endmodule

// File: rtl/data_path_sequencer.sv
// Host-side sequencer for data_path: storage loads, locator reset and controller run.
// Optional RUN watchdog is enabled by defining DATA_PATH_SEQ_WATCHDOG_EN (adds WDOG_CYCLES).
module data_path_sequencer
    import data_path_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CODE_W = CODE_W_DEF,
`ifdef DATA_PATH_SEQ_WATCHDOG_EN
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
`endif
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_count,
    input  logic [IDX_W-1:0]  cmd_rows,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [CODE_W-1:0] code_write_data,
    output logic              code_is_write,
    output logic [IDX_W-1:0]  code_write_line,
    output logic              code_enable,
    output logic              weight_is_write,
    output logic [IDX_W-1:0]  weight_write_layer_index,
    output logic [IDX_W-1:0]  weight_write_row_index,
    output logic [DATA_W-1:0] weight_write_data,
    output logic              input_is_write,
    output logic [IDX_W-1:0]  input_write_layer_index,
    output logic [IDX_W-1:0]  input_write_row_index,
    output logic [DATA_W-1:0] input_write_data,
    output logic              label_is_write,
    output logic [IDX_W-1:0]  label_write_layer_index,
    output logic [IDX_W-1:0]  label_write_row_index,
    output logic [DATA_W-1:0] label_write_data,
    output logic              locator_reset,
    output logic              controller_enable,
    input  logic [IDX_W-1:0]  code_index,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [IDX_W-1:0]  ZERO_IDX  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  ONE_IDX   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [CODE_W-1:0] ZERO_CODE = {CODE_W{1'b0}};

    seq_state_t       state_r;
    seq_state_t       next_state_s;
    cmd_op_t          target_r;
    logic [IDX_W-1:0] remaining_r;
    logic [IDX_W-1:0] remaining_nxt_s;
    logic [IDX_W-1:0] rows_r;
    logic [IDX_W-1:0] line_r;
    logic [IDX_W-1:0] end_line_r;

    logic accept_s;
    logic load_cmd_s;
    logic run_cmd_s;
    logic bad_cmd_s;
    logic hs_s;
    logic end_match_s;
    logic wdog_hit_s;
    logic code_wr_s;
    logic weight_wr_s;
    logic input_wr_s;
    logic label_wr_s;
    logic mat_wr_s;

    logic [IDX_W-1:0] idx_row_s;
    logic [IDX_W-1:0] idx_layer_s;

    logic s_ready_s;
    logic busy_s;
    logic done_s;
    logic error_s;
    logic locator_s;
    logic enable_s;

    logic              s_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              locator_r;
    logic              enable_r;
    logic              code_wr_r;
    logic              weight_wr_r;
    logic              input_wr_r;
    logic              label_wr_r;
    logic [CODE_W-1:0] code_data_r;
    logic [IDX_W-1:0]  code_line_r;
    logic [DATA_W-1:0] mat_data_r;
    logic [IDX_W-1:0]  mat_row_r;
    logic [IDX_W-1:0]  mat_layer_r;

    assign accept_s    = cmd_valid && (state_r == ST_IDLE);
    assign load_cmd_s  = accept_s && op_is_load(cmd_op);
    assign run_cmd_s   = accept_s && (cmd_op == OP_RUN);
    assign bad_cmd_s   = accept_s && !op_is_load(cmd_op) && (cmd_op != OP_RUN);
    assign hs_s        = s_valid && s_ready_r;
    assign end_match_s = (code_index == end_line_r);
    assign code_wr_s   = hs_s && (target_r == OP_LOAD_CODE);
    assign weight_wr_s = hs_s && (target_r == OP_LOAD_WEIGHT);
    assign input_wr_s  = hs_s && (target_r == OP_LOAD_INPUT);
    assign label_wr_s  = hs_s && (target_r == OP_LOAD_LABEL);
    assign mat_wr_s    = weight_wr_s || input_wr_s || label_wr_s;

`ifdef DATA_PATH_SEQ_WATCHDOG_EN
    logic [31:0] wdog_cnt_r;

    // RUN cycle counter; restarts whenever the sequencer is outside RUN.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wdog_cnt_r <= 32'd0;
        end else if (state_r == ST_RUN) begin
            wdog_cnt_r <= wdog_cnt_r + 32'd1;
        end else begin
            wdog_cnt_r <= 32'd0;
        end
    end

    assign wdog_hit_s = (state_r == ST_RUN) && !end_match_s &&
                        (wdog_cnt_r == 32'(WDOG_CYCLES - 1));
`else
    assign wdog_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; LOAD exits once the registered word budget is exhausted.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_cmd_s) begin
                    next_state_s = ST_RSTLOC;
                end else if (load_cmd_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (remaining_r == ZERO_IDX) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RSTLOC: next_state_s = ST_RUN;
            ST_RUN: begin
                if (end_match_s || wdog_hit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Word budget after this cycle; also drives the registered ready.
    always_comb begin
        remaining_nxt_s = remaining_r;
        if (load_cmd_s) begin
            remaining_nxt_s = cmd_count;
        end else if (hs_s) begin
            remaining_nxt_s = remaining_r - ONE_IDX;
        end else begin
            remaining_nxt_s = remaining_r;
        end
    end

    // Output decode from the next state so every control output is registered.
    always_comb begin
        s_ready_s = (next_state_s == ST_LOAD) && (remaining_nxt_s != ZERO_IDX);
        busy_s    = (next_state_s != ST_IDLE);
        done_s    = (next_state_s == ST_DONE);
        locator_s = (next_state_s == ST_RSTLOC);
        enable_s  = (next_state_s == ST_RUN);
        if (load_cmd_s || run_cmd_s) begin
            error_s = 1'b0;
        end else if (bad_cmd_s || wdog_hit_s) begin
            error_s = 1'b1;
        end else begin
            error_s = error_r;
        end
    end

    // Command context and load counters.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            target_r    <= OP_LOAD_CODE;
            remaining_r <= ZERO_IDX;
            rows_r      <= ONE_IDX;
            line_r      <= ZERO_IDX;
            end_line_r  <= ZERO_IDX;
        end else begin
            remaining_r <= remaining_nxt_s;
            if (load_cmd_s) begin
                target_r <= cmd_op_t'(cmd_op);
                rows_r   <= (cmd_rows == ZERO_IDX) ? ONE_IDX : cmd_rows;
                line_r   <= ZERO_IDX;
            end else if (code_wr_s) begin
                line_r <= line_r + ONE_IDX;
            end else begin
                line_r <= line_r;
            end
            if (run_cmd_s) begin
                end_line_r <= cmd_count;
            end else begin
                end_line_r <= end_line_r;
            end
        end
    end

    matrix_index_counter #(
        .IDX_W (IDX_W)
    ) u_matrix_index_counter (
        .clk   (clk_clk),
        .reset (reset_reset),
        .clear (load_cmd_s),
        .step  (mat_wr_s),
        .rows  (rows_r),
        .row   (idx_row_s),
        .layer (idx_layer_s)
    );

    // Output registers; write payloads only load on their own strobe.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            locator_r   <= 1'b0;
            enable_r    <= 1'b0;
            code_wr_r   <= 1'b0;
            weight_wr_r <= 1'b0;
            input_wr_r  <= 1'b0;
            label_wr_r  <= 1'b0;
            code_data_r <= ZERO_CODE;
            code_line_r <= ZERO_IDX;
            mat_data_r  <= ZERO_DATA;
            mat_row_r   <= ZERO_IDX;
            mat_layer_r <= ZERO_IDX;
        end else begin
            s_ready_r   <= s_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            locator_r   <= locator_s;
            enable_r    <= enable_s;
            code_wr_r   <= code_wr_s;
            weight_wr_r <= weight_wr_s;
            input_wr_r  <= input_wr_s;
            label_wr_r  <= label_wr_s;
            if (code_wr_s) begin
                code_data_r <= s_data[CODE_W-1:0];
                code_line_r <= line_r;
            end else begin
                code_data_r <= code_data_r;
                code_line_r <= code_line_r;
            end
            if (mat_wr_s) begin
                mat_data_r  <= s_data;
                mat_row_r   <= idx_row_s;
                mat_layer_r <= idx_layer_s;
            end else begin
                mat_data_r  <= mat_data_r;
                mat_row_r   <= mat_row_r;
                mat_layer_r <= mat_layer_r;
            end
        end
    end

    // Only one matrix target is loaded at a time, so the payload registers are shared.
    assign s_ready                  = s_ready_r;
    assign busy                     = busy_r;
    assign done                     = done_r;
    assign error                    = error_r;
    assign locator_reset            = locator_r;
    assign controller_enable        = enable_r;
    assign code_enable              = enable_r;
    assign code_is_write            = code_wr_r;
    assign code_write_data          = code_data_r;
    assign code_write_line          = code_line_r;
    assign weight_is_write          = weight_wr_r;
    assign weight_write_layer_index = mat_layer_r;
    assign weight_write_row_index   = mat_row_r;
    assign weight_write_data        = mat_data_r;
    assign input_is_write           = input_wr_r;
    assign input_write_layer_index  = mat_layer_r;
    assign input_write_row_index    = mat_row_r;
    assign input_write_data         = mat_data_r;
    assign label_is_write           = label_wr_r;
    assign label_write_layer_index  = mat_layer_r;
    assign label_write_row_index    = mat_row_r;
    assign label_write_data         = mat_data_r;

endmodule

// File: tb/tb_data_path_sequencer.sv
// Self-checking bench for data_path_sequencer: randomized loads and runs against a simple index/timing model.
module tb_data_path_sequencer;

    localparam int DATA_W = 48;
    localparam int CODE_W = 12;
    localparam int IDX_W  = 32;
    localparam int OUTS_W = 7 + CODE_W + 1 + IDX_W + 3 * (1 + 2 * IDX_W + DATA_W);

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_count;
    logic [IDX_W-1:0]  cmd_rows;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [CODE_W-1:0] code_write_data;
    logic              code_is_write;
    logic [IDX_W-1:0]  code_write_line;
    logic              code_enable;
    logic              weight_is_write;
    logic [IDX_W-1:0]  weight_write_layer_index;
    logic [IDX_W-1:0]  weight_write_row_index;
    logic [DATA_W-1:0] weight_write_data;
    logic              input_is_write;
    logic [IDX_W-1:0]  input_write_layer_index;
    logic [IDX_W-1:0]  input_write_row_index;
    logic [DATA_W-1:0] input_write_data;
    logic              label_is_write;
    logic [IDX_W-1:0]  label_write_layer_index;
    logic [IDX_W-1:0]  label_write_row_index;
    logic [DATA_W-1:0] label_write_data;
    logic              locator_reset;
    logic              controller_enable;
    logic [IDX_W-1:0]  code_index;
    logic              busy;
    logic              done;
    logic              error;
    logic [OUTS_W-1:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    assign outs = {s_ready, busy, done, error, locator_reset, controller_enable, code_enable,
                   code_write_data, code_is_write, code_write_line,
                   weight_is_write, weight_write_layer_index, weight_write_row_index, weight_write_data,
                   input_is_write, input_write_layer_index, input_write_row_index, input_write_data,
                   label_is_write, label_write_layer_index, label_write_row_index, label_write_data};

    data_path_sequencer #(
        .DATA_W (DATA_W),
        .CODE_W (CODE_W),
`ifdef DATA_PATH_SEQ_WATCHDOG_EN
        .WDOG_CYCLES (16),
`endif
        .IDX_W  (IDX_W)
    ) dut (
        .clk_clk                  (clk_clk),
        .reset_reset              (reset_reset),
        .cmd_valid                (cmd_valid),
        .cmd_op                   (cmd_op),
        .cmd_count                (cmd_count),
        .cmd_rows                 (cmd_rows),
        .s_valid                  (s_valid),
        .s_ready                  (s_ready),
        .s_data                   (s_data),
        .code_write_data          (code_write_data),
        .code_is_write            (code_is_write),
        .code_write_line          (code_write_line),
        .code_enable              (code_enable),
        .weight_is_write          (weight_is_write),
        .weight_write_layer_index (weight_write_layer_index),
        .weight_write_row_index   (weight_write_row_index),
        .weight_write_data        (weight_write_data),
        .input_is_write           (input_is_write),
        .input_write_layer_index  (input_write_layer_index),
        .input_write_row_index    (input_write_row_index),
        .input_write_data         (input_write_data),
        .label_is_write           (label_is_write),
        .label_write_layer_index  (label_write_layer_index),
        .label_write_row_index    (label_write_row_index),
        .label_write_data         (label_write_data),
        .locator_reset            (locator_reset),
        .controller_enable        (controller_enable),
        .code_index               (code_index),
        .busy                     (busy),
        .done                     (done),
        .error                    (error)
    );

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_count   = 32'd0;
        cmd_rows    = 32'd0;
        s_valid     = 1'b0;
        s_data      = 48'd0;
        code_index  = 32'd0;
        repeat (3) tick();
        checks++;
        if (outs !== {OUTS_W{1'b0}}) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected all zero", outs);
        end
        reset_reset = 1'b0;
        tick();
        checks++;
        if ({busy, s_ready, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: busy/s_ready/done got %b, expected 000", {busy, s_ready, done});
        end
    endtask

    // Load n words into target op; model: k-th word goes to line k, row k%rows, layer k/rows.
    task automatic do_load(input logic [2:0] op, input int n, input int rows,
                           input bit stall, input bit seq_data, input string name);
        int eff_rows;
        int sent;
        int cyc;
        int last_hs;
        bit hs;
        bit seen_done;
        logic [DATA_W-1:0] word;
        logic [3:0] exp_wr;
        logic [3:0] act_wr;
        logic [IDX_W-1:0] a_row;
        logic [IDX_W-1:0] a_layer;
        logic [DATA_W-1:0] a_data;
        eff_rows  = (rows == 0) ? 1 : rows;
        sent      = 0;
        last_hs   = 0;
        seen_done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = IDX_W'(n);
        cmd_rows  = IDX_W'(rows);
        tick();
        cyc    = 1;
        cmd_op = 3'd4;
        while (!seen_done && cyc < 4 * n + 20) begin
            cmd_valid = 1'($urandom_range(0, 1));
            s_valid   = (sent < n) && (!stall || ($urandom_range(0, 3) != 0));
            s_data    = seq_data ? DATA_W'(32'hA + 32'(sent)) : DATA_W'({$urandom, $urandom});
            checks++;
            if (s_ready !== (sent < n)) begin
                errors++;
                $display("FAIL %s_s_ready: cycle %0d got %b, expected %b", name, cyc, s_ready, (sent < n));
            end
            hs   = s_valid && (sent < n);
            word = s_data;
            tick();
            cyc++;
            exp_wr = hs ? (4'b0001 << op) : 4'b0000;
            act_wr = {label_is_write, input_is_write, weight_is_write, code_is_write};
            checks++;
            if (act_wr !== exp_wr) begin
                errors++;
                $display("FAIL %s_strobe: cycle %0d got %b, expected %b", name, cyc, act_wr, exp_wr);
            end
            if (hs) begin
                if (op == 3'd0) begin
                    checks++;
                    if (code_write_data !== word[CODE_W-1:0] || code_write_line !== IDX_W'(sent)) begin
                        errors++;
                        $display("FAIL %s_code_word: got line %0d data %h, expected line %0d data %h",
                                 name, code_write_line, code_write_data, sent, word[CODE_W-1:0]);
                    end
                end else begin
                    case (op)
                        3'd1: begin a_layer = weight_write_layer_index; a_row = weight_write_row_index; a_data = weight_write_data; end
                        3'd2: begin a_layer = input_write_layer_index;  a_row = input_write_row_index;  a_data = input_write_data;  end
                        default: begin a_layer = label_write_layer_index; a_row = label_write_row_index; a_data = label_write_data; end
                    endcase
                    checks++;
                    if (a_layer !== IDX_W'(sent / eff_rows) || a_row !== IDX_W'(sent % eff_rows) || a_data !== word) begin
                        errors++;
                        $display("FAIL %s_mat_word: got (%0d,%0d) %h, expected (%0d,%0d) %h", name,
                                 a_layer, a_row, a_data, sent / eff_rows, sent % eff_rows, word);
                    end
                end
                sent++;
                last_hs = cyc - 1;
            end
            checks++;
            if ({busy, error, locator_reset, controller_enable, code_enable} !== 5'b10000) begin
                errors++;
                $display("FAIL %s_ctrl: cycle %0d busy/err/loc/en/cen got %b, expected 10000", name, cyc,
                         {busy, error, locator_reset, controller_enable, code_enable});
            end
            if (done === 1'b1) seen_done = 1'b1;
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        checks++;
        if (!seen_done || sent != n || cyc != last_hs + 2) begin
            errors++;
            $display("FAIL %s_done: seen %0d at cycle %0d with %0d words, expected cycle %0d with %0d words",
                     name, seen_done, cyc, sent, last_hs + 2, n);
        end
        if (!stall) begin
            checks++;
            if (cyc != n + 2) begin
                errors++;
                $display("FAIL %s_latency: done at cycle %0d, expected %0d", name, cyc, n + 2);
            end
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle: busy/done got %b, expected 00", name, {busy, done});
        end
    endtask

    // Run to end line start+e with code_index counting up from start while enabled.
    task automatic do_run(input logic [IDX_W-1:0] start, input int e, input string name);
        logic [IDX_W-1:0] end_line;
        logic [6:0] exp;
        logic [6:0] act;
        bit en_seen;
        end_line   = start + IDX_W'(e);
        code_index = start;
        cmd_valid  = 1'b1;
        cmd_op     = 3'd4;
        cmd_count  = end_line;
        cmd_rows   = IDX_W'($urandom);
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= e + 4; c++) begin
            exp = {1'b0, 1'b0, (c == 1), (c >= 2 && c <= 2 + e), (c >= 2 && c <= 2 + e), (c == 3 + e), (c <= 3 + e)};
            act = {s_ready, error, locator_reset, controller_enable, code_enable, done, busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s_c%0d: rdy/err/loc/en/cen/done/busy got %b, expected %b", name, c, act, exp);
            end
            en_seen = controller_enable;
            if (c < e + 4) begin
                tick();
                if (en_seen) code_index = code_index + 32'd1;
            end
        end
    endtask

    task automatic test_load_code();
        do_load(3'd0, 3, 0, 1'b0, 1'b1, "load_code3");
    endtask

    task automatic test_load_weight();
        do_load(3'd1, 5, 2, 1'b0, 1'b0, "load_weight5");
    endtask

    task automatic test_load_input_zero();
        do_load(3'd2, 0, 3, 1'b0, 1'b0, "load_input0");
    endtask

    task automatic test_load_random();
        for (int k = 0; k < 6; k++) begin
            do_load(3'($urandom_range(0, 3)), int'($urandom_range(1, 12)), int'($urandom_range(0, 4)),
                    1'b1, 1'b0, "load_rand");
        end
    endtask

    task automatic test_run();
        do_run(32'd0, 7, "run7");
        do_run(32'd0, 0, "run_immediate");
        do_run(32'hFFFF_FFFD, 5, "run_wrap");
        do_run(IDX_W'($urandom), int'($urandom_range(1, 20)), "run_rand");
    endtask

    task automatic test_reset_mid_load();
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_count = 32'd10;
        cmd_rows  = 32'd0;
        tick();
        cmd_valid = 1'b0;
        s_valid   = 1'b1;
        repeat (4) begin
            s_data = DATA_W'({$urandom, $urandom});
            tick();
        end
        reset_reset = 1'b1;
        tick();
        checks++;
        if (outs !== {OUTS_W{1'b0}}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h, expected all zero", outs);
        end
        reset_reset = 1'b0;
        s_valid     = 1'b0;
        tick();
        do_load(3'd0, 3, 0, 1'b0, 1'b0, "after_reset_code");
        do_load(3'd3, 4, 3, 1'b1, 1'b0, "after_reset_label");
    endtask

    task automatic test_illegal_op();
        for (int k = 5; k <= 7; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'(k);
            tick();
            cmd_valid = 1'b0;
            checks++;
            if ({error, busy} !== 2'b10) begin
                errors++;
                $display("FAIL illegal_op%0d: error/busy got %b, expected 10", k, {error, busy});
            end
            tick();
            checks++;
            if ({error, busy, done} !== 3'b100) begin
                errors++;
                $display("FAIL illegal_sticky%0d: error/busy/done got %b, expected 100", k, {error, busy, done});
            end
        end
        do_load(3'd1, 2, 1, 1'b0, 1'b0, "clear_error");
    endtask

    task automatic test_back_to_back();
        do_load(3'd2, 6, 3, 1'b0, 1'b0, "b2b_input");
        do_run(32'd100, 3, "b2b_run");
        do_load(3'd0, 4, 0, 1'b0, 1'b0, "b2b_code");
    endtask

`ifdef DATA_PATH_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        logic [3:0] exp;
        logic [3:0] act;
        code_index = 32'd100;
        cmd_valid  = 1'b1;
        cmd_op     = 3'd4;
        cmd_count  = 32'd5;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            exp = {(c >= 2 && c <= 17), (c >= 2 && c <= 17), (c == 18), (c >= 18)};
            act = {controller_enable, code_enable, done, error};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL watchdog_c%0d: en/cen/done/err got %b, expected %b", c, act, exp);
            end
            if (c < 19) tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_code();
        test_load_weight();
        test_load_input_zero();
        test_load_random();
        test_run();
        test_reset_mid_load();
        test_illegal_op();
        test_back_to_back();
`ifdef DATA_PATH_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
